// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer score player: FSM states,
// score-word field positions and the octave-4 period table.
package buzzer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        PLAY,
        GAP,
        DONE
    } state_t;

    localparam int PERIOD_W = 20;

    localparam logic [15:0] END_MARKER = 16'hFFFF;

    localparam int PITCH_MSB = 15;
    localparam int PITCH_LSB = 12;
    localparam int OCT_MSB   = 11;
    localparam int OCT_LSB   = 10;
    localparam int LOUD_MSB  = 9;
    localparam int LOUD_LSB  = 8;
    localparam int DUR_MSB   = 7;
    localparam int DUR_LSB   = 0;

    // Octave-4 tone periods in 50 MHz clock cycles, C through B.
    localparam logic [PERIOD_W-1:0] BASE_PERIOD [1:12] = '{
        20'd191110, 20'd180388, 20'd170265, 20'd160705,
        20'd151685, 20'd143172, 20'd135139, 20'd127551,
        20'd120395, 20'd113636, 20'd107259, 20'd101238
    };

endpackage

// File: rtl/note_period_lut.sv
// Pitch/octave to PWM period lookup; any pitch outside 1..12 is reported as a rest.
module note_period_lut
    import buzzer_pkg::*;
(
    input  logic [3:0]          pitch,
    input  logic [1:0]          octave,
    output logic [PERIOD_W-1:0] period,
    output logic                rest
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        period = '0;
        rest   = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            if (pitch == 4'(i)) begin
                period = BASE_PERIOD[i] >> octave;
                rest   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/buzzer_note_sequencer.sv
// Score playback: fetches note words from a synchronous ROM and drives the
// buzzer PWM stage with period, loudness and enable for each note plus a gap.
module buzzer_note_sequencer
    import buzzer_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 500_000,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    output logic                score_rd,
    output logic [ADDR_W-1:0]   score_addr,
    input  logic [15:0]         score_data,
    output logic                tune_en,
    output logic [PERIOD_W-1:0] pwm_param,
    output logic [1:0]          loudness,
    output logic                playing,
    output logic                done
);

    localparam int unsigned DUR_MAX = 255 * BEAT_CYCLES;
    localparam int unsigned CNT_MAX = (DUR_MAX > GAP_CYCLES) ? DUR_MAX : GAP_CYCLES;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [CNT_W-1:0]    count;
    logic                note_on;

    logic [PERIOD_W-1:0] lut_period;
    logic                lut_rest;
    logic [7:0]          dur_raw;
    logic [7:0]          dur_units;
    logic                end_marker;

    note_period_lut u_lut (
        .pitch  (score_data[PITCH_MSB:PITCH_LSB]),
        .octave (score_data[OCT_MSB:OCT_LSB]),
        .period (lut_period),
        .rest   (lut_rest)
    );

    assign dur_raw    = score_data[DUR_MSB:DUR_LSB];
    assign dur_units  = (dur_raw == 8'd0) ? 8'd1 : dur_raw;
    assign end_marker = (score_data == END_MARKER);
    assign score_addr = addr;

    // Pause gates the enable combinationally so the tone stops in the same cycle.
    assign tune_en = note_on & ~pause;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            count     <= '0;
            note_on   <= 1'b0;
            score_rd  <= 1'b0;
            pwm_param <= '0;
            loudness  <= '0;
            playing   <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            score_rd <= 1'b0;
            done     <= 1'b0;
            if (stop) begin
                state   <= IDLE;
                addr    <= '0;
                count   <= '0;
                note_on <= 1'b0;
                playing <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= FETCH;
                            addr     <= '0;
                            score_rd <= 1'b1;
                            playing  <= 1'b1;
                        end
                    end
                    FETCH: state <= LATCH;
                    LATCH: begin
                        if (end_marker) begin
                            state   <= DONE;
                            playing <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state    <= PLAY;
                            loudness <= score_data[LOUD_MSB:LOUD_LSB];
                            count    <= CNT_W'(dur_units) * CNT_W'(BEAT_CYCLES);
                            note_on  <= ~lut_rest;
                            if (!lut_rest) pwm_param <= lut_period;
                        end
                    end
                    PLAY: begin
                        if (!pause) begin
                            if (count == CNT_W'(1)) begin
                                state   <= GAP;
                                note_on <= 1'b0;
                                count   <= CNT_W'(GAP_CYCLES);
                            end else begin
                                count <= count - CNT_W'(1);
                            end
                        end
                    end
                    GAP: begin
                        if (!pause) begin
                            if (count == CNT_W'(1)) begin
                                count <= '0;
                                // The score never wraps: the last address ends playback.
                                if (addr == {ADDR_W{1'b1}}) begin
                                    state   <= DONE;
                                    playing <= 1'b0;
                                    done    <= 1'b1;
                                end else begin
                                    state    <= FETCH;
                                    addr     <= addr + ADDR_W'(1);
                                    score_rd <= 1'b1;
                                end
                            end else begin
                                count <= count - CNT_W'(1);
                            end
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_buzzer_note_sequencer.sv
// Self-checking bench: builds the expected per-cycle playback timeline from the
// score and the pause/stop schedule, and compares the sequencer against it.
module tb_buzzer_note_sequencer;

    localparam int BEAT = 10;
    localparam int GAP  = 3;
    localparam int MAXC = 4200;

    localparam int unsigned BASE_TAB [12] = '{
        191110, 180388, 170265, 160705, 151685, 143172,
        135139, 127551, 120395, 113636, 107259, 101238
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        pause;
    logic        score_rd;
    logic [7:0]  score_addr;
    logic [15:0] score_data;
    logic        tune_en;
    logic [19:0] pwm_param;
    logic [1:0]  loudness;
    logic        playing;
    logic        done;

    buzzer_note_sequencer #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP),
        .ADDR_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .score_rd   (score_rd),
        .score_addr (score_addr),
        .score_data (score_data),
        .tune_en    (tune_en),
        .pwm_param  (pwm_param),
        .loudness   (loudness),
        .playing    (playing),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [0:255];
    always @(posedge clk) if (score_rd) score_data <= rom[score_addr];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit cmp_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: actual %0d, required %0d", name, cyc, act, exp);
        end
    endtask

    // Expected timeline, one entry per cycle after start is driven.
    bit          e_tune [MAXC];
    bit          e_play [MAXC];
    bit          e_done [MAXC];
    bit          e_rd   [MAXC];
    bit          e_lchk [MAXC];
    bit          e_achk [MAXC];
    logic [19:0] e_pwm  [MAXC];
    logic [1:0]  e_loud [MAXC];
    logic [7:0]  e_addr [MAXC];
    logic [19:0] model_pwm = '0;

    task automatic put(input int t, input bit tn, input bit pl, input bit dn, input bit rd,
                       input logic [19:0] pw, input bit lc, input logic [1:0] ld,
                       input bit ac, input logic [7:0] ad);
        if (t >= 0 && t < MAXC) begin
            e_tune[t] = tn; e_play[t] = pl; e_done[t] = dn; e_rd[t] = rd;
            e_pwm[t]  = pw; e_lchk[t] = lc; e_loud[t] = ld;
            e_achk[t] = ac; e_addr[t] = ad;
        end
    endtask

    task automatic build_timeline(input int ncyc, input int p_lo, input int p_hi, input int stop_at);
        int t, a, rem, p;
        bit rest, paused, fin;
        logic [15:0] w;
        logic [19:0] pw;
        logic [1:0]  ld;
        pw = model_pwm;
        for (int i = 0; i < MAXC; i++) put(i, 0, 0, 0, 0, pw, 0, 2'd0, 0, 8'd0);
        t = 1; a = 0; fin = 0;
        while (!fin && t <= ncyc) begin
            put(t, 0, 1, 0, 1, pw, 0, 2'd0, 1, 8'(a)); t++;
            put(t, 0, 1, 0, 0, pw, 0, 2'd0, 0, 8'd0);  t++;
            w = rom[a];
            if (w == 16'hFFFF) begin
                put(t, 0, 0, 1, 0, pw, 0, 2'd0, 0, 8'd0); t++;
                fin = 1;
            end else begin
                p    = int'(w[15:12]);
                rest = (p < 1 || p > 12);
                if (!rest) pw = 20'(BASE_TAB[p-1] >> w[11:10]);
                ld   = w[9:8];
                rem  = ((w[7:0] == 8'd0) ? 1 : int'(w[7:0])) * BEAT;
                while (rem > 0 && t <= ncyc) begin
                    paused = (t >= p_lo && t <= p_hi);
                    put(t, !rest && !paused, 1, 0, 0, pw, !rest && !paused, ld, 0, 8'd0);
                    if (!paused) rem--;
                    t++;
                end
                rem = GAP;
                while (rem > 0 && t <= ncyc) begin
                    paused = (t >= p_lo && t <= p_hi);
                    put(t, 0, 1, 0, 0, pw, 0, 2'd0, 0, 8'd0);
                    if (!paused) rem--;
                    t++;
                end
                if (a == 255) begin
                    put(t, 0, 0, 1, 0, pw, 0, 2'd0, 0, 8'd0); t++;
                    fin = 1;
                end else begin
                    a++;
                end
            end
        end
        for (int i = t; i <= ncyc; i++) put(i, 0, 0, 0, 0, pw, 0, 2'd0, 0, 8'd0);
        if (stop_at > 0)
            for (int i = stop_at + 1; i <= ncyc; i++)
                put(i, 0, 0, 0, 0, e_pwm[stop_at], 0, 2'd0, 1, 8'd0);
    endtask

    // Observations of the DUT, pinned against hand-computed values per scenario.
    int          tune_cnt, first_tune, last_tune, done_cnt, done_cyc, rd_cnt, rd0_cnt;
    logic [19:0] pwm_log  [MAXC];
    logic        tune_log [MAXC];
    logic [7:0]  addr_log [MAXC];

    always @(negedge clk) begin
        if (cmp_active && cyc < MAXC) begin
            check("tune_en",  32'(tune_en),   32'(e_tune[cyc]));
            check("playing",  32'(playing),   32'(e_play[cyc]));
            check("done",     32'(done),      32'(e_done[cyc]));
            check("score_rd", 32'(score_rd),  32'(e_rd[cyc]));
            check("pwm_param", 32'(pwm_param), 32'(e_pwm[cyc]));
            if (e_lchk[cyc]) check("loudness", 32'(loudness), 32'(e_loud[cyc]));
            if (e_achk[cyc]) check("score_addr", 32'(score_addr), 32'(e_addr[cyc]));
            if (tune_en) begin
                tune_cnt++;
                if (first_tune < 0) first_tune = cyc;
                last_tune = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (score_rd) begin
                rd_cnt++;
                if (score_addr == 8'd0) rd0_cnt++;
            end
            pwm_log[cyc]  = pwm_param;
            tune_log[cyc] = tune_en;
            addr_log[cyc] = score_addr;
        end
    end

    task automatic run_scenario(input int ncyc, input int p_lo, input int p_hi,
                                input int stop_at, input int extra_start);
        build_timeline(ncyc, p_lo, p_hi, stop_at);
        tune_cnt = 0; first_tune = -1; last_tune = -1;
        done_cnt = 0; done_cyc = -1; rd_cnt = 0; rd0_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; stop = 1'b0; pause = 1'b0; cyc = 0; cmp_active = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            cyc   = c;
            start = (c == stop_at) || (c == extra_start);
            stop  = (stop_at > 0) && (c == stop_at);
            pause = (p_hi > 0) && (c >= p_lo) && (c <= p_hi);
        end
        @(posedge clk); #1;
        cmp_active = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        model_pwm = e_pwm[ncyc];
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        #2 rst = 1'b1;
        #1;
        check("rst_tune_en",    32'(tune_en),    32'd0);
        check("rst_playing",    32'(playing),    32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_score_rd",   32'(score_rd),   32'd0);
        check("rst_score_addr", 32'(score_addr), 32'd0);
        check("rst_pwm_param",  32'(pwm_param),  32'd0);
        check("rst_loudness",   32'(loudness),   32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Single A4 note; a start pulse mid-note is ignored.
        rom[0] = 16'hA205; rom[1] = 16'hFFFF;
        run_scenario(60, 0, 0, 0, 20);
        check("t1_first_tune", 32'(first_tune), 32'd3);
        check("t1_tune_cycles", 32'(tune_cnt), 32'd50);
        check("t1_pwm", 32'(pwm_log[3]), 32'd113636);
        check("t1_done_cycle", 32'(done_cyc), 32'd58);
        check("t1_done_count", 32'(done_cnt), 32'd1);

        // Octave shifts.
        rom[0] = 16'hA703; rom[1] = 16'h1C01; rom[2] = 16'hFFFF;
        run_scenario(55, 0, 0, 0, 0);
        check("t2_pwm_a5", 32'(pwm_log[3]), 32'd56818);
        check("t2_pwm_c7", 32'(pwm_log[38]), 32'd23888);
        check("t2_tune_cycles", 32'(tune_cnt), 32'd40);
        check("t2_done_cycle", 32'(done_cyc), 32'd53);

        // Rest between two notes keeps the previous period.
        rom[0] = 16'h5102; rom[1] = 16'h0004; rom[2] = 16'h8202; rom[3] = 16'hFFFF;
        run_scenario(100, 0, 0, 0, 0);
        check("t3_rest_tune", 32'(tune_log[50]), 32'd0);
        check("t3_rest_pwm", 32'(pwm_log[50]), 32'd151685);
        check("t3_pwm_g4", 32'(pwm_log[73]), 32'd127551);
        check("t3_tune_cycles", 32'(tune_cnt), 32'd40);
        check("t3_done_cycle", 32'(done_cyc), 32'd98);

        // Pause 7 cycles into the note, held 20 cycles.
        rom[0] = 16'hA205; rom[1] = 16'hFFFF;
        run_scenario(80, 10, 29, 0, 0);
        check("t4_tune_cycles", 32'(tune_cnt), 32'd50);
        check("t4_pause_tune", 32'(tune_log[15]), 32'd0);
        check("t4_note_span", 32'(last_tune - first_tune + 1), 32'd70);
        check("t4_done_cycle", 32'(done_cyc), 32'd78);

        // Stop with start in the same cycle, then replay from address 0.
        run_scenario(30, 0, 0, 20, 0);
        check("t5_tune_after_stop", 32'(tune_log[21]), 32'd0);
        check("t5_addr_after_stop", 32'(addr_log[21]), 32'd0);
        check("t5_no_done", 32'(done_cnt), 32'd0);
        run_scenario(60, 0, 0, 0, 0);
        check("t5_replay_first_tune", 32'(first_tune), 32'd3);
        check("t5_replay_done_cycle", 32'(done_cyc), 32'd58);

        // Full ROM of one-beat notes, no end marker: must stop after address 255.
        for (int i = 0; i < 256; i++)
            rom[i] = {4'((i % 12) + 1), 2'((i / 12) % 4), 2'(i % 4), 8'd1};
        run_scenario(3845, 0, 0, 0, 0);
        check("t6_fetches", 32'(rd_cnt), 32'd256);
        check("t6_addr0_fetches", 32'(rd0_cnt), 32'd1);
        check("t6_done_cycle", 32'(done_cyc), 32'd3841);

        // Asynchronous reset in the first gap.
        run_scenario(13, 0, 0, 0, 0);
        check("t6_pre_rst_pwm", 32'(pwm_param), 32'd191110);
        #1 rst = 1'b1;
        #1;
        check("arst_tune_en",    32'(tune_en),    32'd0);
        check("arst_playing",    32'(playing),    32'd0);
        check("arst_done",       32'(done),       32'd0);
        check("arst_score_rd",   32'(score_rd),   32'd0);
        check("arst_score_addr", 32'(score_addr), 32'd0);
        check("arst_pwm_param",  32'(pwm_param),  32'd0);
        check("arst_loudness",   32'(loudness),   32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/buzzer_note_sequencer.md
Name: buzzer_note_sequencer

Overview:
- Score-playback stage directly upstream of the buzzer tone PWM generator.
- Fetches packed note words from a synchronous score ROM and converts pitch and octave into a 20-bit PWM period.
- Drives the PWM enable, period and loudness for each note's duration, then inserts an articulation gap.
- Stops on an end marker or on command.

Parameters:
- BEAT_CYCLES, 12_500_000, clk cycles per duration unit (0.25 s at 50 MHz).
- GAP_CYCLES, 500_000, silent cycles appended after every note (must be ≥1).
- ADDR_W, 8, score ROM address width.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begin playback from address 0.
- stop  in  1  single-cycle pulse; abort playback.
- pause  in  1  level; freezes playback while high.
- score_rd  out  1  ROM read strobe.
- score_addr  out  ADDR_W  ROM address.
- score_data  in  16  ROM data, valid the cycle after score_rd.
- tune_en  out  1  enable to the PWM stage.
- pwm_param  out  20  period in clk cycles, to the PWM stage.
- loudness  out  2  duty select, to the PWM stage.
- playing  out  1  high in FETCH, LATCH, PLAY and GAP.
- done  out  1  one-cycle pulse on natural end of score.

Clocking and reset:
- One clock; reset is asynchronous and active-high.
- Reset values: state IDLE; all outputs 0; internal counters 0.

Behaviour:
- Score word format:
  - [15:12] pitch: 0 = rest, 1..12 = C..B, 13..14 treated as rest, 15 = end marker when word == 16'hFFFF.
  - [11:10] octave: 0 = octave 4, n = octave 4+n.
  - [9:8] loudness.
  - [7:0] duration units; 0 is treated as 1.
- Period: pwm_param = BASE_PERIOD[pitch] >> octave. BASE_PERIOD is the octave-4 table at 50 MHz, rounded: C 191110, C# 180388, D 170265, D# 160705, E 151685, F 143172, F# 135139, G 127551, G# 120395, A 113636, A# 107259, B 101238.
- FSM states: IDLE, FETCH, LATCH, PLAY, GAP, DONE.
  - IDLE: start (with stop low) → FETCH, addr = 0.
  - FETCH (1 cycle): score_rd = 1, score_addr = addr → LATCH.
  - LATCH (1 cycle): capture score_data.
    - End marker → DONE.
    - Otherwise load the note registers and the duration counter (dur × BEAT_CYCLES) → PLAY.
  - PLAY: tune_en = 1 unless rest. pwm_param and loudness are registered and stable for the whole note. The counter decrements each cycle; on reaching 1 → GAP.
  - GAP: tune_en = 0; pwm_param holds. Runs exactly GAP_CYCLES cycles, then addr+1 → FETCH.
    - If addr == 2^ADDR_W−1, go → DONE instead; no wrap.
  - DONE (1 cycle): done = 1 → IDLE.
- Latency: start at edge 0 → tune_en high after edge 3. A note of d units holds tune_en for exactly d × BEAT_CYCLES cycles.
- Rest notes: tune_en stays 0 for the full duration; pwm_param keeps its previous value.
- Pause:
  - In PLAY or GAP, counters freeze and tune_en is forced to 0.
  - On release, playback resumes with the remaining count and tune_en restored.
  - In FETCH or LATCH, pause has no effect until PLAY is reached.
- Stop: from any state → IDLE on the next edge; tune_en = 0 and addr = 0 that cycle; no done pulse.
- start and stop in the same cycle: stop wins.
- start while not in IDLE: ignored.
- Reset mid-note: immediate return to reset values; the PWM stage sees tune_en drop asynchronously.

Decomposition:
- Package buzzer_pkg holds:
  - BASE_PERIOD[1..12] constant array;
  - the state enum;
  - the END_MARKER constant 16'hFFFF;
  - field-slice localparams for the score word.
- Sub-module note_period_lut: combinational pitch/octave → 20-bit period, with rest detection.

Test Plan:
1. Score {16'hA205 (A, oct0, loud 2, dur 5), FFFF}, BEAT_CYCLES = 10, GAP_CYCLES = 3 → tune_en high 50 cycles with pwm_param = 113636 and loudness = 2; then 3 gap cycles; then a done pulse 2 cycles later; playing falls.
2. Word 16'hA703 (A, oct1) → pwm_param = 56818, loudness = 3, 30 cycles. Word 16'h1C01 (C, oct3) → pwm_param = 23888.
3. Rest word 16'h0004 between two notes → tune_en low for 40+3 cycles; pwm_param unchanged from the previous note.
4. Pause asserted 7 cycles into a 50-cycle note, held 20 cycles → tune_en low during the pause; note completes after 43 further enabled cycles; total note span 70 cycles.
5. stop pulsed mid-PLAY, with start in the same cycle → IDLE next cycle, tune_en = 0, score_addr = 0, no done pulse. A later start replays from address 0.
6. ROM filled with 256 dur-1 notes and no end marker → done pulse after address 255's gap, with no fetch of address 0. An async rst pulse mid-GAP → all outputs 0 immediately.
